mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-stage controller between the EX/MEM pipeline register and the data-side cache port.
- Issues a single load or store per instruction, holds the request until `dhit`, then presents load data to the MEM/WB register.
- Generates the MEM/WB enable/flush controls and a MEM stall to the hazard unit.
- Tracks the sticky halt condition and counts memory stall cycles for the CPU tracker.

Parameters:
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- valid_EX_MEM  input  1  EX/MEM holds a real instruction (not a bubble).
- dREN_EX_MEM  input  1  instruction is a load.
- dWEN_EX_MEM  input  1  instruction is a store.
- result_EX_MEM  input  32  ALU result, used as the data address.
- rdat2_EX_MEM  input  32  store data.
- halt_EX_MEM  input  1  halt instruction in MEM.
- stall_ext  input  1  stall from another source (e.g. icache miss); freezes all pipeline registers.
- dhit  input  1  cache completed the current request this cycle.
- dmemload  input  32  cache read data, valid when `dhit`.
- dmemREN  output  1  read request to cache.
- dmemWEN  output  1  write request to cache.
- dmemaddr  output  32  request address.
- dmemstore  output  32  write data.
- mem_data_MEM  output  32  load data to MEM/WB.
- mem_stall  output  1  MEM stage not complete; upstream must hold.
- enable_MEM_WB  output  1  MEM/WB register enable.
- flush_MEM_WB  output  1  MEM/WB loads a bubble.
- halt  output  1  sticky halt.
- stall_cycles  output  CNT_W  saturating count of cycles with `mem_stall`=1.

Behaviour:
- Interface fixed: one clock `CLK`; `nRST` asynchronous active-low.
- FSM states:
  - IDLE: no outstanding access.
  - REQ: request driven to cache.
  - DONE: access finished while `stall_ext` held the pipeline.
  - HALTED: terminal.
- Reset (async, any state, including mid-request): state=IDLE; `load_q`=0; `halt`=0; `stall_cycles`=0. Combinational outputs then evaluate to `dmemREN`=`dmemWEN`=0, `mem_stall`=0, `enable_MEM_WB`=1, `flush_MEM_WB`=0. An in-flight cache request is dropped.
- Access decode: `acc` = `valid_EX_MEM` & (`dREN_EX_MEM` | `dWEN_EX_MEM`). If both enables are set, treat as a store: `dWEN` has priority and `dmemREN`=0.
- Request outputs: in IDLE or REQ with `acc`=1, `dmemREN`/`dmemWEN` are driven combinationally in the same cycle the instruction enters MEM, with `dmemaddr`=`result_EX_MEM` and `dmemstore`=`rdat2_EX_MEM`. They are deasserted in DONE and HALTED. When no request is active, `dmemaddr`/`dmemstore` are 0.
- IDLE:
  - `acc` & !`dhit` -> REQ.
  - `acc` & `dhit` & `stall_ext` -> DONE.
  - `acc` & `dhit` & !`stall_ext` -> stay IDLE (zero-wait hit).
  - `halt_EX_MEM` & `valid_EX_MEM` & !`acc` -> HALTED.
- REQ:
  - hold the request unchanged until `dhit`.
  - `dhit` & `stall_ext` -> DONE.
  - `dhit` & !`stall_ext` -> IDLE.
- DONE: hold with no request; when `stall_ext`=0 -> IDLE. A new access is not issued until the EX/MEM contents advance.
- HALTED: `halt`=1 sticky; no requests; stays until `nRST`.
- Load data:
  - On any `dhit` with a load, `load_q` <= `dmemload`.
  - `mem_data_MEM` = `dhit` ? `dmemload` : `load_q`, giving zero-latency bypass on the hit cycle.
- `mem_stall` = `acc` & !`dhit` & state∈{IDLE,REQ}.
- `enable_MEM_WB` = !`stall_ext`.
- `flush_MEM_WB` = `mem_stall` & !`stall_ext`. MEM/WB receives a bubble while waiting, so writeback never duplicates.
- `stall_cycles`: increments on each cycle with `mem_stall`=1 and saturates at all-ones (no wrap).
- Simultaneous `dhit` and `nRST` low: reset wins.
- `dhit` in DONE/HALTED/IDLE with `acc`=0: ignored, no state change.

Decomposition:
- Add to `data_path_muxs_pkg` (or a new `mem_stage_pkg`): `typedef enum logic [1:0] {IDLE, REQ, DONE, HALTED} mem_state_t`.
- Take `word_t` and `WORD_W` from `cpu_types_pkg`.
- Sub-module: `sat_counter` (CNT_W, inc, count) for `stall_cycles`.
- Ports grouped in a `mem_access_ctrl_if` interface with modports `mac` and `tb`.

Test Plan:
- Zero-wait load: `acc` load, addr 0x0000_0040, `dhit` same cycle, `dmemload`=0xDEAD_BEEF -> `mem_stall`=0, `mem_data_MEM`=0xDEAD_BEEF, state stays IDLE, `stall_cycles`=0.
- 3-cycle-miss store to 0x0000_0100, data 0x1234_5678 -> `dmemWEN`=1 with constant addr/data for 3 cycles, `mem_stall`=1 and `flush_MEM_WB`=1 for 2 cycles, cleared on the `dhit` cycle; `stall_cycles`=2.
- Hit under `stall_ext`: load hits while `stall_ext`=1 for 4 cycles -> DONE, `dmemREN`=0 after the hit, `mem_data_MEM` holds `load_q` value 0xCAFE_0001, only one cache request issued.
- Both `dREN` and `dWEN` set -> only `dmemWEN`=1.
- Halt after store completes -> `halt`=1 the next cycle and persists through 10 cycles of random `dhit`/`acc`; no requests issued.
- `nRST` pulsed low mid-REQ -> immediately `dmemREN`=0, `halt`=0, `stall_cycles`=0, state IDLE. Force `stall_cycles` near max -> saturates at 0xFFFF_FFFF.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access_ctrl_pkg
//   Shared types and constants for the memory-stage access controller.
//   Contents: data word width and type, FSM state encoding.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

   localparam int WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;

   // Memory-stage FSM encoding
   localparam logic [1:0] ST_IDLE   = 2'd0; // no outstanding access
   localparam logic [1:0] ST_REQ    = 2'd1; // request held at the cache
   localparam logic [1:0] ST_DONE   = 2'd2; // finished, pipeline frozen externally
   localparam logic [1:0] ST_HALTED = 2'd3; // terminal

endpackage : mem_access_ctrl_pkg
`default_nettype wire

// File: rtl/mem_access_ctrl_sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sat_counter
//   Up-counter that stops at all-ones instead of wrapping.
//   Ports: CLK, nRST (async active-low), inc (count enable),
//          count [CNT_W-1:0] (current value).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule : sat_counter
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access_ctrl
//   Memory-stage controller between EX/MEM and the data-side cache port.
//   Issues one load/store per instruction, holds it until dhit, bypasses
//   load data on the hit cycle, drives MEM/WB enable/flush and the MEM
//   stall, tracks sticky halt and counts memory stall cycles.
//   Ports:
//     CLK, nRST                      clock, async active-low reset
//     valid/dREN/dWEN/result/rdat2/halt _EX_MEM   EX/MEM register fields
//     stall_ext                      external pipeline freeze
//     dhit, dmemload                 cache completion and read data
//     dmemREN, dmemWEN, dmemaddr, dmemstore       cache request
//     mem_data_MEM                   load data to MEM/WB
//     mem_stall, enable_MEM_WB, flush_MEM_WB      pipeline control
//     halt, stall_cycles             status to the CPU tracker
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             valid_EX_MEM,
   input  logic             dREN_EX_MEM,
   input  logic             dWEN_EX_MEM,
   input  word_t            result_EX_MEM,
   input  word_t            rdat2_EX_MEM,
   input  logic             halt_EX_MEM,
   input  logic             stall_ext,
   input  logic             dhit,
   input  word_t            dmemload,
   output logic             dmemREN,
   output logic             dmemWEN,
   output word_t            dmemaddr,
   output word_t            dmemstore,
   output word_t            mem_data_MEM,
   output logic             mem_stall,
   output logic             enable_MEM_WB,
   output logic             flush_MEM_WB,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cycles
);

   logic [1:0] state;
   logic [1:0] state_nxt;
   word_t      load_q;
   logic       acc;
   logic       is_store;
   logic       req_active;

   assign acc      = valid_EX_MEM & (dREN_EX_MEM | dWEN_EX_MEM);
   // A store wins when both enables are set
   assign is_store = dWEN_EX_MEM;

   // Request is live only in IDLE/REQ; gated by nRST so a request caught
   // by reset is dropped at once rather than after the next edge.
   assign req_active = nRST & acc & ((state == ST_IDLE) | (state == ST_REQ));

   assign dmemREN   = req_active & ~is_store;
   assign dmemWEN   = req_active &  is_store;
   assign dmemaddr  = req_active ? result_EX_MEM : '0;
   assign dmemstore = req_active ? rdat2_EX_MEM  : '0;

   assign mem_stall     = req_active & ~dhit;
   assign enable_MEM_WB = ~stall_ext;
   // Bubble into MEM/WB while waiting so writeback never repeats
   assign flush_MEM_WB  = mem_stall & ~stall_ext;

   assign mem_data_MEM = dhit ? dmemload : load_q;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (acc) begin
               if (!dhit)          state_nxt = ST_REQ;
               else if (stall_ext) state_nxt = ST_DONE;
            end else if (halt_EX_MEM && valid_EX_MEM) begin
               state_nxt = ST_HALTED;
            end
         end
         ST_REQ: begin
            if (dhit) state_nxt = stall_ext ? ST_DONE : ST_IDLE;
         end
         ST_DONE: begin
            if (!stall_ext) state_nxt = ST_IDLE;
         end
         ST_HALTED: state_nxt = ST_HALTED;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= ST_IDLE;
         load_q <= '0;
         halt   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (dhit && req_active && !is_store) begin
            load_q <= dmemload;
         end
         if (state_nxt == ST_HALTED) begin
            halt <= 1'b1;
         end
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (mem_stall),
      .count (stall_cycles)
   );

endmodule : mem_access_ctrl
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Directed self-checking bench for mem_access_ctrl. A second instance with a
//   3-bit counter exercises stall-counter saturation.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_mem_access_ctrl;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        valid_EX_MEM, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM;
   logic [31:0] result_EX_MEM, rdat2_EX_MEM, dmemload;
   logic        stall_ext, dhit;
   logic        dmemREN, dmemWEN, mem_stall, enable_MEM_WB, flush_MEM_WB, halt;
   logic [31:0] dmemaddr, dmemstore, mem_data_MEM, stall_cycles;

   // saturation instance
   logic        s_nRST, s_valid, s_dhit;
   logic        s_dmemREN, s_dmemWEN, s_mem_stall, s_en, s_flush, s_halt;
   logic [31:0] s_addr, s_store, s_data;
   logic [2:0]  s_cnt;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   mem_access_ctrl #(.CNT_W(32)) dut (
      .CLK(CLK), .nRST(nRST),
      .valid_EX_MEM(valid_EX_MEM), .dREN_EX_MEM(dREN_EX_MEM),
      .dWEN_EX_MEM(dWEN_EX_MEM), .result_EX_MEM(result_EX_MEM),
      .rdat2_EX_MEM(rdat2_EX_MEM), .halt_EX_MEM(halt_EX_MEM),
      .stall_ext(stall_ext), .dhit(dhit), .dmemload(dmemload),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
      .dmemstore(dmemstore), .mem_data_MEM(mem_data_MEM),
      .mem_stall(mem_stall), .enable_MEM_WB(enable_MEM_WB),
      .flush_MEM_WB(flush_MEM_WB), .halt(halt), .stall_cycles(stall_cycles)
   );

   mem_access_ctrl #(.CNT_W(3)) dut_sat (
      .CLK(CLK), .nRST(s_nRST),
      .valid_EX_MEM(s_valid), .dREN_EX_MEM(1'b1), .dWEN_EX_MEM(1'b0),
      .result_EX_MEM(32'h0000_0080), .rdat2_EX_MEM(32'h0),
      .halt_EX_MEM(1'b0), .stall_ext(1'b0), .dhit(s_dhit),
      .dmemload(32'h0),
      .dmemREN(s_dmemREN), .dmemWEN(s_dmemWEN), .dmemaddr(s_addr),
      .dmemstore(s_store), .mem_data_MEM(s_data),
      .mem_stall(s_mem_stall), .enable_MEM_WB(s_en),
      .flush_MEM_WB(s_flush), .halt(s_halt), .stall_cycles(s_cnt)
   );

   // Drive new inputs just after the rising edge
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      valid_EX_MEM = 0; dREN_EX_MEM = 0; dWEN_EX_MEM = 0; halt_EX_MEM = 0;
      result_EX_MEM = 0; rdat2_EX_MEM = 0; dmemload = 0;
      stall_ext = 0; dhit = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      nRST = 0;
      s_nRST = 0; s_valid = 0; s_dhit = 0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checks++; if (dmemREN !== 1'b0) begin errors++; $display("FAIL reset_dmemREN got=%0b exp=0", dmemREN); end
      checks++; if (dmemWEN !== 1'b0) begin errors++; $display("FAIL reset_dmemWEN got=%0b exp=0", dmemWEN); end
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_mem_stall got=%0b exp=0", mem_stall); end
      checks++; if (enable_MEM_WB !== 1'b1) begin errors++; $display("FAIL reset_enable got=%0b exp=1", enable_MEM_WB); end
      checks++; if (flush_MEM_WB !== 1'b0) begin errors++; $display("FAIL reset_flush got=%0b exp=0", flush_MEM_WB); end
      checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got=%0b exp=0", halt); end
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
      checks++; if (mem_data_MEM !== 32'd0) begin errors++; $display("FAIL reset_mem_data got=%h exp=0", mem_data_MEM); end
      @(posedge CLK); #1;
      nRST = 1;
      step();
   endtask

   task automatic test_zero_wait_load();
      valid_EX_MEM = 1; dREN_EX_MEM = 1; result_EX_MEM = 32'h0000_0040;
      dhit = 1; dmemload = 32'hDEAD_BEEF;
      @(negedge CLK);
      checks++; if (dmemREN !== 1'b1) begin errors++; $display("FAIL zw_dmemREN got=%0b exp=1", dmemREN); end
      checks++; if (dmemaddr !== 32'h40) begin errors++; $display("FAIL zw_addr got=%h exp=00000040", dmemaddr); end
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL zw_mem_stall got=%0b exp=0", mem_stall); end
      checks++; if (mem_data_MEM !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zw_bypass got=%h exp=deadbeef", mem_data_MEM); end
      step();
      clear_inputs();
      @(negedge CLK);
      checks++; if (mem_data_MEM !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zw_load_q got=%h exp=deadbeef", mem_data_MEM); end
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL zw_stall_cycles got=%0d exp=0", stall_cycles); end
      checks++; if (dmemaddr !== 32'd0) begin errors++; $display("FAIL zw_idle_addr got=%h exp=0", dmemaddr); end
      step();
   endtask

   task automatic test_miss_store();
      valid_EX_MEM = 1; dWEN_EX_MEM = 1;
      result_EX_MEM = 32'h0000_0100; rdat2_EX_MEM = 32'h1234_5678;
      for (int c = 0; c < 3; c++) begin
         dhit = (c == 2);
         @(negedge CLK);
         checks++; if (dmemWEN !== 1'b1) begin errors++; $display("FAIL miss_dmemWEN c=%0d got=%0b exp=1", c, dmemWEN); end
         checks++; if (dmemREN !== 1'b0) begin errors++; $display("FAIL miss_dmemREN c=%0d got=%0b exp=0", c, dmemREN); end
         checks++; if (dmemaddr !== 32'h100) begin errors++; $display("FAIL miss_addr c=%0d got=%h exp=00000100", c, dmemaddr); end
         checks++; if (dmemstore !== 32'h1234_5678) begin errors++; $display("FAIL miss_store c=%0d got=%h exp=12345678", c, dmemstore); end
         checks++; if (mem_stall !== (c != 2)) begin errors++; $display("FAIL miss_mem_stall c=%0d got=%0b exp=%0b", c, mem_stall, c != 2); end
         checks++; if (flush_MEM_WB !== (c != 2)) begin errors++; $display("FAIL miss_flush c=%0d got=%0b exp=%0b", c, flush_MEM_WB, c != 2); end
         step();
      end
      clear_inputs();
      @(negedge CLK);
      checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL miss_stall_cycles got=%0d exp=2", stall_cycles); end
      checks++; if (dmemWEN !== 1'b0) begin errors++; $display("FAIL miss_after_WEN got=%0b exp=0", dmemWEN); end
      step();
   endtask

   task automatic test_hit_under_stall();
      int reqs = 0;
      valid_EX_MEM = 1; dREN_EX_MEM = 1; result_EX_MEM = 32'h0000_0200;
      stall_ext = 1; dhit = 1; dmemload = 32'hCAFE_0001;
      @(negedge CLK);
      if (dmemREN) reqs++;
      checks++; if (mem_data_MEM !== 32'hCAFE_0001) begin errors++; $display("FAIL hus_bypass got=%h exp=cafe0001", mem_data_MEM); end
      checks++; if (enable_MEM_WB !== 1'b0) begin errors++; $display("FAIL hus_enable got=%0b exp=0", enable_MEM_WB); end
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL hus_mem_stall got=%0b exp=0", mem_stall); end
      step();
      dhit = 0; dmemload = 32'h0;
      for (int c = 1; c < 4; c++) begin
         @(negedge CLK);
         if (dmemREN) reqs++;
         checks++; if (dmemREN !== 1'b0) begin errors++; $display("FAIL hus_done_REN c=%0d got=%0b exp=0", c, dmemREN); end
         checks++; if (mem_data_MEM !== 32'hCAFE_0001) begin errors++; $display("FAIL hus_load_q c=%0d got=%h exp=cafe0001", c, mem_data_MEM); end
         checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL hus_done_stall c=%0d got=%0b exp=0", c, mem_stall); end
         step();
      end
      // Freeze lifts; instruction still in EX/MEM for this cycle only
      stall_ext = 0;
      @(negedge CLK);
      if (dmemREN) reqs++;
      checks++; if (dmemREN !== 1'b0) begin errors++; $display("FAIL hus_release_REN got=%0b exp=0", dmemREN); end
      step();
      clear_inputs();
      @(negedge CLK);
      checks++; if (reqs !== 1) begin errors++; $display("FAIL hus_req_count got=%0d exp=1", reqs); end
      checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL hus_stall_cycles got=%0d exp=2", stall_cycles); end
      step();
   endtask

   task automatic test_both_enables();
      valid_EX_MEM = 1; dREN_EX_MEM = 1; dWEN_EX_MEM = 1;
      result_EX_MEM = 32'h0000_0300; rdat2_EX_MEM = 32'h0BAD_F00D; dhit = 1;
      @(negedge CLK);
      checks++; if (dmemWEN !== 1'b1) begin errors++; $display("FAIL both_WEN got=%0b exp=1", dmemWEN); end
      checks++; if (dmemREN !== 1'b0) begin errors++; $display("FAIL both_REN got=%0b exp=0", dmemREN); end
      step();
      clear_inputs();
      step();
   endtask

   task automatic test_halt();
      // store completes zero-wait
      valid_EX_MEM = 1; dWEN_EX_MEM = 1; result_EX_MEM = 32'h0000_0400;
      rdat2_EX_MEM = 32'h5555_AAAA; dhit = 1;
      step();
      clear_inputs();
      valid_EX_MEM = 1; halt_EX_MEM = 1;
      @(negedge CLK);
      checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_before got=%0b exp=0", halt); end
      step();
      clear_inputs();
      for (int c = 0; c < 10; c++) begin
         valid_EX_MEM = 1'($urandom_range(0, 1));
         dREN_EX_MEM  = 1'($urandom_range(0, 1));
         dWEN_EX_MEM  = 1'($urandom_range(0, 1));
         dhit         = 1'($urandom_range(0, 1));
         result_EX_MEM = $urandom;
         @(negedge CLK);
         checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_sticky c=%0d got=%0b exp=1", c, halt); end
         checks++; if ({dmemREN, dmemWEN} !== 2'b00) begin errors++; $display("FAIL halt_no_req c=%0d got=%b exp=00", c, {dmemREN, dmemWEN}); end
         checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL halt_stall c=%0d got=%0b exp=0", c, mem_stall); end
         step();
      end
      clear_inputs();
      @(negedge CLK);
      checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL halt_stall_cycles got=%0d exp=2", stall_cycles); end
   endtask

   task automatic test_reset_mid_req();
      nRST = 0;
      #2;
      nRST = 1;
      step();
      valid_EX_MEM = 1; dREN_EX_MEM = 1; result_EX_MEM = 32'h0000_0500;
      @(negedge CLK);
      checks++; if (halt !== 1'b0) begin errors++; $display("FAIL rst_halt_cleared got=%0b exp=0", halt); end
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got=%0b exp=1", mem_stall); end
      step();
      @(negedge CLK);
      checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL rst_pre_count got=%0d exp=1", stall_cycles); end
      nRST = 0;
      #1;
      checks++; if (dmemREN !== 1'b0) begin errors++; $display("FAIL rst_mid_REN got=%0b exp=0", dmemREN); end
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got=%0b exp=0", mem_stall); end
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", stall_cycles); end
      checks++; if (halt !== 1'b0) begin errors++; $display("FAIL rst_mid_halt got=%0b exp=0", halt); end
      clear_inputs();
      step();
      nRST = 1;
      step();
      @(negedge CLK);
      checks++; if (dmemREN !== 1'b0) begin errors++; $display("FAIL rst_after_REN got=%0b exp=0", dmemREN); end
   endtask

   task automatic test_saturation();
      int exp_cnt = 0;
      s_nRST = 1; s_valid = 1; s_dhit = 0;
      for (int c = 0; c < 11; c++) begin
         step();
         if (exp_cnt < 7) exp_cnt++;
         @(negedge CLK);
         checks++; if (s_cnt !== 3'(exp_cnt)) begin errors++; $display("FAIL sat_count c=%0d got=%0d exp=%0d", c, s_cnt, exp_cnt); end
      end
      s_valid = 0;
   endtask

   initial begin
      test_reset();
      test_zero_wait_load();
      test_miss_store();
      test_hit_under_stall();
      test_both_enables();
      test_halt();
      test_reset_mid_req();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mem_access_ctrl
`default_nettype wire
